neon_axil_arbiter: RTL and testbench

Two-requester round-robin arbiter and AXI4-Lite master sequencer for the NeonIp S00_AXI register slave (four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC). Each requester issues single-word read or write commands on a simple valid/ready port. The block serialises them and drives one AXI4-Lite transaction at a time, then returns the response to the owning requester. It sits between on-chip control logic and the NeonIp slave, replacing the testbench master in the integrated design.

---
 rtl/neon_axil_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_neon_axil_arbiter.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neon_axil_arbiter.sv
// neon_axil_arbiter: two-requester round-robin arbiter in front of a single
// AXI4-Lite master port for the NeonIp S00_AXI register slave.
// Optional build macro NEON_ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
module neon_axil_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESETN,

   input  logic                r0_valid,
   output logic                r0_ready,
   input  logic                r0_we,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   output logic                r0_rvalid,
   output logic [DATA_W-1:0]   r0_rdata,
   output logic [1:0]          r0_resp,

   input  logic                r1_valid,
   output logic                r1_ready,
   input  logic                r1_we,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   output logic                r1_rvalid,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic [1:0]          r1_resp,

   output logic [ADDR_W-1:0]   M_AXI_AWADDR,
   output logic [2:0]          M_AXI_AWPROT,
   output logic                M_AXI_AWVALID,
   input  logic                M_AXI_AWREADY,
   output logic [DATA_W-1:0]   M_AXI_WDATA,
   output logic [DATA_W/8-1:0] M_AXI_WSTRB,
   output logic                M_AXI_WVALID,
   input  logic                M_AXI_WREADY,
   input  logic [1:0]          M_AXI_BRESP,
   input  logic                M_AXI_BVALID,
   output logic                M_AXI_BREADY,
   output logic [ADDR_W-1:0]   M_AXI_ARADDR,
   output logic [2:0]          M_AXI_ARPROT,
   output logic                M_AXI_ARVALID,
   input  logic                M_AXI_ARREADY,
   input  logic [DATA_W-1:0]   M_AXI_RDATA,
   input  logic [1:0]          M_AXI_RRESP,
   input  logic                M_AXI_RVALID,
   output logic                M_AXI_RREADY,

   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR_DATA,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_RESPOND
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;     // 0 = requester 0, 1 = requester 1
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          resp_q, resp_d;
`ifndef NEON_ARB_FIXED_PRIO_EN
   logic                last_grant_q, last_grant_d;
`endif

   logic                gnt0, gnt1;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   // Grant decision among currently valid requesters
   always_comb begin
`ifdef NEON_ARB_FIXED_PRIO_EN
      gnt0 = r0_valid;
      gnt1 = r1_valid & ~r0_valid;
`else
      // On a tie the requester that did not win last time is served
      gnt0 = r0_valid & (~r1_valid | last_grant_q);
      gnt1 = r1_valid & (~r0_valid | ~last_grant_q);
`endif
      sel_we    = gnt1 ? r1_we    : r0_we;
      sel_addr  = gnt1 ? r1_addr  : r0_addr;
      sel_wdata = gnt1 ? r1_wdata : r0_wdata;
      sel_addr[1:0] = 2'b00;
   end

   // State and datapath registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         rdata_q      <= '0;
         resp_q       <= '0;
`ifndef NEON_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
`ifndef NEON_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // Next-state logic and FSM-driven handshake outputs
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
`ifndef NEON_ARB_FIXED_PRIO_EN
      last_grant_d  = last_grant_q;
`endif
      r0_ready      = 1'b0;
      r1_ready      = 1'b0;
      r0_rvalid     = 1'b0;
      r1_rvalid     = 1'b0;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (gnt0 || gnt1) begin
               r0_ready  = gnt0;
               r1_ready  = gnt1;
               owner_d   = gnt1;
               addr_d    = sel_addr;
               wdata_d   = sel_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
`ifndef NEON_ARB_FIXED_PRIO_EN
               last_grant_d = gnt1;
`endif
               state_d   = sel_we ? S_WR_ADDR_DATA : S_RD_ADDR;
            end
         end
         S_WR_ADDR_DATA: begin
            // AW and W complete independently; each valid drops on its own handshake
            M_AXI_AWVALID = ~aw_done_q;
            M_AXI_WVALID  = ~w_done_q;
            aw_done_d     = aw_done_q | M_AXI_AWREADY;
            w_done_d      = w_done_q  | M_AXI_WREADY;
            if (aw_done_d && w_done_d) begin
               state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) begin
               resp_d  = M_AXI_BRESP;
               rdata_d = '0;
               state_d = S_RESPOND;
            end
         end
         S_RD_ADDR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) begin
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) begin
               rdata_d = M_AXI_RDATA;
               resp_d  = M_AXI_RRESP;
               state_d = S_RESPOND;
            end
         end
         S_RESPOND: begin
            r0_rvalid = ~owner_q;
            r1_rvalid = owner_q;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_WDATA  = wdata_q;
   assign M_AXI_WSTRB  = '1;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign r0_rdata     = rdata_q;
   assign r1_rdata     = rdata_q;
   assign r0_resp      = resp_q;
   assign r1_resp      = resp_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_neon_axil_arbiter.sv
// Testbench for neon_axil_arbiter: two requester drivers, an AXI4-Lite
// register-slave model with programmable latencies and error injection,
// and a transaction-level reference model of arbitration and responses.
module tb_neon_axil_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   logic ACLK = 1'b0;
   logic ARESETN;
   logic r0_valid, r0_ready, r0_we, r0_rvalid;
   logic [AW-1:0] r0_addr;
   logic [DW-1:0] r0_wdata, r0_rdata;
   logic [1:0] r0_resp;
   logic r1_valid, r1_ready, r1_we, r1_rvalid;
   logic [AW-1:0] r1_addr;
   logic [DW-1:0] r1_wdata, r1_rdata;
   logic [1:0] r1_resp;
   logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
   logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic M_AXI_RVALID, M_AXI_RREADY;
   logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
   logic [DW/8-1:0] M_AXI_WSTRB;
   logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
   logic busy;

   neon_axil_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_resp(r0_resp),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_resp(r1_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .busy(busy)
   );

   always #5 ACLK = ~ACLK;

   typedef struct packed {logic we; logic [3:0] addr; logic [31:0] data;} cmd_t;
   typedef struct packed {logic [31:0] data; logic [1:0] resp;} rsp_t;

   cmd_t q0[$], q1[$], cq0[$], cq1[$];
   rsp_t got0[$], got1[$], exp0[$], exp1[$];
   int grants[$], exp_grants[$];
   logic [31:0] mem[4];
   logic [31:0] model_mem[4];
   int total = 0, bad = 0;
   bit acc0, acc1;

   // slave knobs and state
   bit rand_lat = 0, rd_err = 0, wr_err = 0;
   int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
   int b_count = 0;
   bit aw_got, w_got, ar_got, b_fire, r_fire, aw_arm, w_arm, b_arm, ar_arm, r_arm;
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic [3:0] aw_a, ar_a;
   logic [31:0] w_d;

   // AXI4-Lite register slave: decisions made on the falling edge
   initial begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
      forever begin
         @(negedge ACLK);
         if (ARESETN !== 1'b1) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_arm = 0; w_arm = 0; b_arm = 0; ar_arm = 0; r_arm = 0;
            continue;
         end
         // B channel
         if (b_fire) begin
            M_AXI_BVALID = 0; b_fire = 0; b_count++;
         end else if (aw_got && w_got && !M_AXI_BVALID) begin
            if (!b_arm) begin b_arm = 1; b_wait = rand_lat ? int'($urandom_range(0, 3)) : b_lat; end
            if (b_wait > 0) b_wait--;
            else begin
               mem[aw_a[3:2]] = w_d;
               M_AXI_BVALID = 1; M_AXI_BRESP = wr_err ? 2'b10 : 2'b00;
               aw_got = 0; w_got = 0; b_arm = 0;
            end
         end
         // R channel
         if (r_fire) begin
            M_AXI_RVALID = 0; r_fire = 0;
         end else if (ar_got && !M_AXI_RVALID) begin
            if (!r_arm) begin r_arm = 1; r_wait = rand_lat ? int'($urandom_range(0, 3)) : r_lat; end
            if (r_wait > 0) r_wait--;
            else begin
               M_AXI_RVALID = 1;
               M_AXI_RDATA  = rd_err ? 32'hDEADBEEF : mem[ar_a[3:2]];
               M_AXI_RRESP  = rd_err ? 2'b10 : 2'b00;
               ar_got = 0; r_arm = 0;
            end
         end
         // AW / W / AR channels
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         if (M_AXI_AWVALID && !aw_got) begin
            if (!aw_arm) begin aw_arm = 1; aw_wait = rand_lat ? int'($urandom_range(0, 3)) : aw_lat; end
            if (aw_wait > 0) aw_wait--;
            else begin M_AXI_AWREADY = 1; aw_got = 1; aw_arm = 0; aw_a = M_AXI_AWADDR; end
         end
         if (M_AXI_WVALID && !w_got) begin
            if (!w_arm) begin w_arm = 1; w_wait = rand_lat ? int'($urandom_range(0, 3)) : w_lat; end
            if (w_wait > 0) w_wait--;
            else begin M_AXI_WREADY = 1; w_got = 1; w_arm = 0; w_d = M_AXI_WDATA; end
         end
         if (M_AXI_ARVALID && !ar_got) begin
            if (!ar_arm) begin ar_arm = 1; ar_wait = rand_lat ? int'($urandom_range(0, 3)) : ar_lat; end
            if (ar_wait > 0) ar_wait--;
            else begin M_AXI_ARREADY = 1; ar_got = 1; ar_arm = 0; ar_a = M_AXI_ARADDR; end
         end
         if (M_AXI_BVALID && M_AXI_BREADY) b_fire = 1;
         if (M_AXI_RVALID && M_AXI_RREADY) r_fire = 1;
      end
   end

   // Requester 0 driver: presents queue head, pops after acceptance
   initial begin
      r0_valid = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
      forever begin
         @(negedge ACLK);
         if (ARESETN !== 1'b1) begin r0_valid = 0; acc0 = 0; continue; end
         if (acc0) begin void'(q0.pop_front()); acc0 = 0; end
         if (q0.size() > 0) begin
            r0_valid = 1; r0_we = q0[0].we; r0_addr = q0[0].addr; r0_wdata = q0[0].data;
         end else r0_valid = 0;
         #1;
         if (r0_valid && r0_ready) begin acc0 = 1; grants.push_back(0); end
      end
   end

   // Requester 1 driver
   initial begin
      r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
      forever begin
         @(negedge ACLK);
         if (ARESETN !== 1'b1) begin r1_valid = 0; acc1 = 0; continue; end
         if (acc1) begin void'(q1.pop_front()); acc1 = 0; end
         if (q1.size() > 0) begin
            r1_valid = 1; r1_we = q1[0].we; r1_addr = q1[0].addr; r1_wdata = q1[0].data;
         end else r1_valid = 0;
         #1;
         if (r1_valid && r1_ready) begin acc1 = 1; grants.push_back(1); end
      end
   end

   // Response collector; responses must never go to both requesters at once
   always @(negedge ACLK) begin
      if (ARESETN === 1'b1) begin
         if (r0_rvalid) got0.push_back({r0_rdata, r0_resp});
         if (r1_rvalid) got1.push_back({r1_rdata, r1_resp});
         if (r0_rvalid || r1_rvalid) begin
            total++;
            if (r0_rvalid && r1_rvalid) begin
               bad++; $display("FAIL rvalid_exclusive: r0_rvalid=1 r1_rvalid=1, required only one");
            end
         end
      end
   end

   task automatic apply_reset();
      ARESETN = 0;
      q0.delete(); q1.delete(); got0.delete(); got1.delete(); grants.delete();
      for (int i = 0; i < 4; i++) begin mem[i] = '0; model_mem[i] = '0; end
      rand_lat = 0; rd_err = 0; wr_err = 0;
      aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1;
      @(negedge ACLK);
   endtask

   // Reference model: commands served one at a time, tie broken against the
   // previous winner (or always toward requester 0 under fixed priority)
   task automatic build_expected();
      int lg = 1;
      int i0 = 0, i1 = 0;
      exp0.delete(); exp1.delete(); exp_grants.delete();
      while (i0 < cq0.size() || i1 < cq1.size()) begin
         bit v0 = (i0 < cq0.size());
         bit v1 = (i1 < cq1.size());
         int w;
         cmd_t c;
         rsp_t r;
`ifdef NEON_ARB_FIXED_PRIO_EN
         w = v0 ? 0 : 1;
`else
         if (v0 && v1) w = (lg == 0) ? 1 : 0;
         else          w = v0 ? 0 : 1;
`endif
         lg = w;
         exp_grants.push_back(w);
         if (w == 0) begin c = cq0[i0]; i0++; end
         else        begin c = cq1[i1]; i1++; end
         if (c.we) begin
            model_mem[c.addr[3:2]] = c.data;
            r = {32'h0, wr_err ? 2'b10 : 2'b00};
         end else if (rd_err) r = {32'hDEADBEEF, 2'b10};
         else r = {model_mem[c.addr[3:2]], 2'b00};
         if (w == 0) exp0.push_back(r); else exp1.push_back(r);
      end
   endtask

   // Launch cq0/cq1 and wait (bounded) for every expected response
   task automatic run_cmds(output bit done);
      build_expected();
      got0.delete(); got1.delete(); grants.delete();
      q0 = cq0; q1 = cq1;
      done = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge ACLK);
         if (got0.size() >= exp0.size() && got1.size() >= exp1.size() && !busy) begin
            done = 1; break;
         end
      end
      repeat (3) @(negedge ACLK);
   endtask

   task automatic test_reset();
      ARESETN = 0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
         bad++; $display("FAIL reset_axi_handshake: got %b want 00000",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
      end
      total++;
      if ({r0_ready, r1_ready, r0_rvalid, r1_rvalid} !== 4'b0) begin
         bad++; $display("FAIL reset_req_handshake: got %b want 0000", {r0_ready, r1_ready, r0_rvalid, r1_rvalid});
      end
      total++;
      if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA} !== '0) begin
         bad++; $display("FAIL reset_addr_data: aw=%h ar=%h w=%h want 0", M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA);
      end
      total++;
      if ({r0_rdata, r0_resp, r1_rdata, r1_resp} !== '0) begin
         bad++; $display("FAIL reset_rsp: r0=%h/%h r1=%h/%h want 0", r0_rdata, r0_resp, r1_rdata, r1_resp);
      end
      total++;
      if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) begin
         bad++; $display("FAIL reset_const: wstrb=%h awprot=%b arprot=%b want f/000/000",
            M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT);
      end
      apply_reset();
   endtask

   task automatic test_write_readback();
      bit done;
      apply_reset();
      cq0.delete(); cq1.delete();
      for (int i = 0; i < 4; i++) cq0.push_back({1'b1, 4'(i * 4), 32'(i + 1)});
      for (int i = 0; i < 4; i++) cq0.push_back({1'b0, 4'(i * 4), 32'h0});
      run_cmds(done);
      total++; if (!done) begin bad++; $display("FAIL readback_timeout: got %0d responses want 8", got0.size()); end
      total++; if (got1.size() != 0) begin bad++; $display("FAIL readback_r1_quiet: got %0d r1 pulses want 0", got1.size()); end
      total++; if (got0.size() != 8) begin bad++; $display("FAIL readback_count: got %0d want 8", got0.size()); end
      for (int i = 0; i < 8 && i < got0.size(); i++) begin
         rsp_t want = (i < 4) ? {32'h0, 2'b00} : {32'(i - 3), 2'b00};
         total++;
         if (got0[i] !== want) begin
            bad++; $display("FAIL readback_rsp[%0d]: got %h/%b want %h/%b", i, got0[i].data, got0[i].resp, want.data, want.resp);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit done;
      apply_reset();
      cq0.delete(); cq1.delete();
      for (int i = 0; i < 4; i++) begin
         cq0.push_back({1'b1, 4'(i * 4), 32'hA000_0000 | 32'(i)});
         cq1.push_back({1'b1, 4'(i * 4), 32'hB000_0000 | 32'(i)});
      end
      run_cmds(done);
      total++; if (!done) begin bad++; $display("FAIL simul_timeout: r0=%0d r1=%0d responses want 4/4", got0.size(), got1.size()); end
      total++; if (grants.size() != 8) begin bad++; $display("FAIL simul_grant_count: got %0d want 8", grants.size()); end
      for (int i = 0; i < 8 && i < grants.size(); i++) begin
         total++;
         if (grants[i] != (i % 2)) begin bad++; $display("FAIL simul_grant[%0d]: got r%0d want r%0d", i, grants[i], i % 2); end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[i] !== (32'hB000_0000 | 32'(i))) begin
            bad++; $display("FAIL simul_mem[%0d]: got %h want %h", i, mem[i], 32'hB000_0000 | 32'(i));
         end
      end
   endtask

   task automatic test_aw_w_independent();
      int aw_hi = 0, w_hi = 0, b0;
      bit addr_ok = 1;
      apply_reset();
      aw_lat = 0; w_lat = 3; b_lat = 0;
      b0 = b_count;
      q0.push_back({1'b1, 4'b0111, 32'h5A5A_1234});
      for (int c = 0; c < 40 && got0.size() == 0; c++) begin
         @(negedge ACLK);
         if (M_AXI_AWVALID) begin aw_hi++; if (M_AXI_AWADDR !== 4'h4) addr_ok = 0; end
         if (M_AXI_WVALID) begin w_hi++; if (M_AXI_WDATA !== 32'h5A5A_1234 || M_AXI_WSTRB !== 4'hF) addr_ok = 0; end
      end
      repeat (3) @(negedge ACLK);
      total++; if (aw_hi != 1) begin bad++; $display("FAIL awvalid_cycles: got %0d want 1", aw_hi); end
      total++; if (w_hi != 4) begin bad++; $display("FAIL wvalid_cycles: got %0d want 4", w_hi); end
      total++; if (!addr_ok) begin bad++; $display("FAIL aw_w_payload: got unstable/wrong awaddr or wdata, want 4/5a5a1234"); end
      total++; if (b_count - b0 != 1) begin bad++; $display("FAIL b_consumed: got %0d want 1", b_count - b0); end
      total++; if (got0.size() != 1) begin bad++; $display("FAIL aw_w_rsp_count: got %0d want 1", got0.size()); end
      total++; if (mem[1] !== 32'h5A5A_1234) begin bad++; $display("FAIL aw_w_mem: got %h want 5a5a1234", mem[1]); end
   endtask

   task automatic test_error();
      bit done;
      apply_reset();
      rd_err = 1; wr_err = 1;
      cq0.delete(); cq1.delete();
      cq0.push_back({1'b0, 4'h8, 32'h0});
      cq1.push_back({1'b1, 4'h0, 32'h1111_2222});
      run_cmds(done);
      total++; if (!done) begin bad++; $display("FAIL error_timeout: r0=%0d r1=%0d want 1/1", got0.size(), got1.size()); end
      total++;
      if (got0.size() != 1 || got0[0] !== {32'hDEADBEEF, 2'b10}) begin
         bad++; $display("FAIL error_read: got n=%0d %h want deadbeef/10", got0.size(), got0.size() ? got0[0] : '0);
      end
      total++;
      if (got1.size() != 1 || got1[0] !== {32'h0, 2'b10}) begin
         bad++; $display("FAIL error_write: got n=%0d %h want 00000000/10", got1.size(), got1.size() ? got1[0] : '0);
      end
      rd_err = 0; wr_err = 0;
   endtask

   task automatic test_reset_mid_read();
      bit seen = 0, done;
      apply_reset();
      r_lat = 10;
      q1.push_back({1'b0, 4'h4, 32'h0});
      for (int c = 0; c < 40; c++) begin
         @(negedge ACLK);
         if (M_AXI_RREADY === 1'b1) begin seen = 1; break; end
      end
      total++; if (!seen) begin bad++; $display("FAIL midrd_reach: got no RREADY want RD_DATA reached"); end
      ARESETN = 0;
      #1;
      total++;
      if ({busy, M_AXI_RREADY, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, r0_rvalid, r1_rvalid} !== 8'b0) begin
         bad++; $display("FAIL midrd_outputs: got %b want 00000000",
            {busy, M_AXI_RREADY, M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, r0_rvalid, r1_rvalid});
      end
      total++;
      if ({M_AXI_ARADDR, r1_rdata, r1_resp} !== '0) begin
         bad++; $display("FAIL midrd_values: araddr=%h rdata=%h resp=%b want 0", M_AXI_ARADDR, r1_rdata, r1_resp);
      end
      repeat (3) @(negedge ACLK);
      ARESETN = 1;
      r_lat = 0;
      repeat (15) @(negedge ACLK);
      total++; if (got1.size() != 0) begin bad++; $display("FAIL midrd_no_rsp: got %0d r1 responses want 0", got1.size()); end
      cq0.delete(); cq1.delete();
      cq0.push_back({1'b1, 4'hC, 32'h1357_9BDF});
      cq0.push_back({1'b0, 4'hC, 32'h0});
      run_cmds(done);
      total++;
      if (!done || got0.size() != 2 || got0[1] !== {32'h1357_9BDF, 2'b00}) begin
         bad++; $display("FAIL midrd_recover: got n=%0d %h want 13579bdf/00", got0.size(), got0.size() > 1 ? got0[1] : '0);
      end
   endtask

   task automatic test_random();
      bit done;
      apply_reset();
      rand_lat = 1;
      cq0.delete(); cq1.delete();
      for (int i = 0; i < 12; i++) begin
         cq0.push_back({1'($urandom), 4'($urandom), 32'($urandom)});
         cq1.push_back({1'($urandom), 4'($urandom), 32'($urandom)});
      end
      run_cmds(done);
      total++; if (!done) begin bad++; $display("FAIL random_timeout: r0=%0d r1=%0d want 12/12", got0.size(), got1.size()); end
      total++; if (grants.size() != exp_grants.size()) begin bad++; $display("FAIL random_grant_count: got %0d want %0d", grants.size(), exp_grants.size()); end
      for (int i = 0; i < exp_grants.size() && i < grants.size(); i++) begin
         total++;
         if (grants[i] != exp_grants[i]) begin bad++; $display("FAIL random_grant[%0d]: got r%0d want r%0d", i, grants[i], exp_grants[i]); end
      end
      for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
         total++;
         if (got0[i] !== exp0[i]) begin bad++; $display("FAIL random_r0[%0d]: got %h want %h", i, got0[i], exp0[i]); end
      end
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
         total++;
         if (got1[i] !== exp1[i]) begin bad++; $display("FAIL random_r1[%0d]: got %h want %h", i, got1[i], exp1[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem[i] !== model_mem[i]) begin bad++; $display("FAIL random_mem[%0d]: got %h want %h", i, mem[i], model_mem[i]); end
      end
   endtask

`ifdef NEON_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      bit done;
      apply_reset();
      cq0.delete(); cq1.delete();
      for (int i = 0; i < 8; i++) begin
         cq0.push_back({1'b1, 4'($urandom), 32'($urandom)});
         cq1.push_back({1'b1, 4'($urandom), 32'($urandom)});
      end
      run_cmds(done);
      total++; if (!done) begin bad++; $display("FAIL fixed_timeout: r0=%0d r1=%0d want 8/8", got0.size(), got1.size()); end
      for (int i = 0; i < 8 && i < grants.size(); i++) begin
         total++;
         if (grants[i] != 0) begin bad++; $display("FAIL fixed_grant[%0d]: got r%0d want r0", i, grants[i]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_readback();
      test_simultaneous();
      test_aw_w_independent();
      test_error();
      test_reset_mid_read();
      test_random();
`ifdef NEON_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
